// File: rtl/mips_imem_loader_pkg.sv
// Shared types and constants for the MIPS instruction-memory boot loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [5:0]  HLT_OPCODE       = 6'h3f;
  localparam logic [31:0] HLT_WORD_DEFAULT = {HLT_OPCODE, 26'd0};
  localparam int          WORD_BYTES       = 4;

  function automatic logic is_hlt(input logic [31:0] w, input logic [31:0] hlt);
    return w == hlt;
  endfunction

endpackage

// File: rtl/mips_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = loader side, slave = stream source / memory side.
interface mips_imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  s_data, s_valid,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_word_assembler.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid pulses the cycle
// after the last byte, and word holds until the next word completes.
module mips_word_assembler
  import mips_loader_pkg::*;
(
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [23:0] shift_reg;
  logic [1:0]  idx_reg;
  logic [31:0] word_reg;
  logic        valid_reg;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      idx_reg   <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (clr) begin
        shift_reg <= '0;
        idx_reg   <= '0;
      end else if (byte_valid) begin
        shift_reg <= {shift_reg[15:0], byte_data};
        idx_reg   <= idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          word_reg  <= {shift_reg, byte_data};
          valid_reg <= 1'b1;
        end
      end
    end
  end

  assign word_valid = valid_reg;
  assign word       = word_reg;

endmodule

// File: rtl/mips_imem_loader.sv
// Boot loader: streams bytes into instruction memory from address 0 up to the HLT word,
// then releases the core. Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module mips_imem_loader
  import mips_loader_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_WORDS = 1 << ADDR_W,
  parameter logic [31:0] HLT_WORD  = HLT_WORD_DEFAULT
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   start,
  mips_imem_loader_if.master     bus,
  output logic [ADDR_W:0]        word_count,
  output logic                   busy,
  output logic                   core_run,
  output logic                   err
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

  loader_state_t     state_reg, state_next;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic              core_run_reg, err_reg;
  logic              clr, byte_acc, word_valid;
  logic [31:0]       word;

  // The write cycle blocks the stream so the assembler never overruns its output word.
  assign bus.s_ready = ((state_reg == LOAD) || (state_reg == CHECK)) && !word_valid;
  assign byte_acc    = bus.s_valid && bus.s_ready;

  mips_word_assembler u_asm (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clr        (clr),
    .byte_valid (byte_acc && (state_reg == LOAD)),
    .byte_data  (bus.s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  assign bus.mem_we    = word_valid;
  assign bus.mem_wdata = word;
  assign bus.mem_addr  = word_valid ? count_reg[ADDR_W-1:0] : addr_hold_reg;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_HLT = CHECK;
  logic [7:0] xor_reg;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      xor_reg <= '0;
    end else if (clr) begin
      xor_reg <= '0;
    end else if (byte_acc && (state_reg == LOAD)) begin
      xor_reg <= xor_reg ^ bus.s_data;
    end
  end
`else
  localparam loader_state_t AFTER_HLT = DONE;
`endif

  always_comb begin
    state_next = state_reg;
    clr        = 1'b0;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next = LOAD;
          clr        = 1'b1;
        end
      end
      LOAD: begin
        if (word_valid) begin
          if (is_hlt(word, HLT_WORD)) begin
            state_next = AFTER_HLT;
          end else if (count_reg == MAX_CNT - 1'b1) begin
            state_next = ERR;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (byte_acc) begin
          state_next = (bus.s_data == xor_reg) ? DONE : ERR;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      addr_hold_reg <= '0;
      core_run_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      core_run_reg <= (state_next == DONE);
      err_reg      <= (state_next == ERR);
      if (clr) begin
        count_reg <= '0;
      end else if (word_valid && (count_reg != MAX_CNT)) begin
        count_reg <= count_reg + 1'b1;
      end
      if (word_valid) begin
        addr_hold_reg <= count_reg[ADDR_W-1:0];
      end
    end
  end

  assign word_count = count_reg;
  assign busy       = (state_reg == LOAD) || (state_reg == CHECK);
  assign core_run   = core_run_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Scoreboard bench for mips_imem_loader: a full-size instance and a 4-word instance
// share one byte stream; sel steers s_valid to one of them.
module tb_mips_imem_loader;
  import mips_loader_pkg::*;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic       sel;
  logic [7:0] s_data;
  logic       s_valid;

  logic [10:0] wc0, wc1;
  logic        busy0, busy1, run0, run1, err0, err1;

  int total = 0;
  int bad   = 0;
  int wr0   = 0;
  int wr1   = 0;

  logic [41:0] q0[$];
  logic [41:0] q1[$];

  logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                            32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                            32'hfc000000};

  always #5 clk1 = ~clk1;

  mips_imem_loader_if #(.ADDR_W(10)) bus0 ();
  mips_imem_loader_if #(.ADDR_W(10)) bus1 ();

  assign bus0.s_data  = s_data;
  assign bus1.s_data  = s_data;
  assign bus0.s_valid = s_valid & ~sel;
  assign bus1.s_valid = s_valid & sel;

  mips_imem_loader #(.ADDR_W(10)) u_dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .start      (start0),
    .bus        (bus0.master),
    .word_count (wc0),
    .busy       (busy0),
    .core_run   (run0),
    .err        (err0)
  );

  mips_imem_loader #(.ADDR_W(10), .MAX_WORDS(4)) u_dut4 (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .start      (start1),
    .bus        (bus1.master),
    .word_count (wc1),
    .busy       (busy1),
    .core_run   (run1),
    .err        (err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitors: every mem_we must match the oldest expected write.
  always @(negedge clk1) begin
    logic [41:0] e;
    if (rst_n && bus0.mem_we) begin
      wr0++;
      $display("dut0 write addr=%0d data=%h", bus0.mem_addr, bus0.mem_wdata);
      if (q0.size() == 0) begin
        check("wr0_unexpected", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("wr0_addr", 32'(bus0.mem_addr), 32'(e[41:32]));
        check("wr0_data", bus0.mem_wdata, e[31:0]);
      end
    end
    if (rst_n && bus1.mem_we) begin
      wr1++;
      $display("dut4 write addr=%0d data=%h", bus1.mem_addr, bus1.mem_wdata);
      if (q1.size() == 0) begin
        check("wr1_unexpected", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("wr1_addr", 32'(bus1.mem_addr), 32'(e[41:32]));
        check("wr1_data", bus1.mem_wdata, e[31:0]);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    s_data  = b;
    s_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      acc = sel ? bus1.s_ready : bus0.s_ready;
      @(negedge clk1);
      if (acc) return;
    end
    check("byte_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gappy);
    int gaps [4] = '{1, 3, 0, 1};
    for (int b = 0; b < 4; b++) begin
      send_byte(w[31-8*b -: 8]);
      if (gappy && gaps[b] > 0) begin
        s_valid = 1'b0;
        repeat (gaps[b]) @(negedge clk1);
      end
    end
  endtask

  task automatic send_prog(input bit gappy);
    for (int i = 0; i < 9; i++) begin
      q0.push_back({10'(i), prog[i]});
      send_word(prog[i], gappy);
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit which);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic check_done0(input string tag);
    repeat (2) @(negedge clk1);
    check({tag, "_wc"},   32'(wc0), 32'd9);
    check({tag, "_run"},  32'(run0), 32'd1);
    check({tag, "_err"},  32'(err0), 32'd0);
    check({tag, "_busy"}, 32'(busy0), 32'd0);
    check({tag, "_left"}, 32'(q0.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
    s_data = 8'h00; s_valid = 1'b0;
    repeat (2) @(negedge clk1);
    check("rst_wc",    32'(wc0), 32'd0);
    check("rst_busy",  32'(busy0), 32'd0);
    check("rst_run",   32'(run0), 32'd0);
    check("rst_err",   32'(err0), 32'd0);
    check("rst_ready", 32'(bus0.s_ready), 32'd0);
    check("rst_we",    32'(bus0.mem_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk1);

    // 1: back-to-back program, with exact write/run latency
    pulse_start(1'b0);
    check("t1_busy", 32'(busy0), 32'd1);
    send_prog(1'b0);
    check("t1_we_last",  32'(bus0.mem_we), 32'd1);
    check("t1_run_early", 32'(run0), 32'd0);
    @(negedge clk1);
    check("t1_run_next", 32'(run0), 32'd1);
    check("t1_writes", 32'(wr0), 32'd9);
    check_done0("t1");

    // 2: same program with valid toggling and stalls
    pulse_start(1'b0);
    check("t2_wc0", 32'(wc0), 32'd0);
    check("t2_run0", 32'(run0), 32'd0);
    send_prog(1'b1);
    check_done0("t2");
    check("t2_writes", 32'(wr0), 32'd18);

    // 5: start during LOAD ignored; start in DONE restarts
    pulse_start(1'b0);
    for (int i = 0; i < 2; i++) begin
      q0.push_back({10'(i), prog[i]});
      send_word(prog[i], 1'b0);
    end
    s_valid = 1'b0;
    @(negedge clk1);
    pulse_start(1'b0);
    check("t5_ign_wc",   32'(wc0), 32'd2);
    check("t5_ign_busy", 32'(busy0), 32'd1);
    for (int i = 2; i < 9; i++) begin
      q0.push_back({10'(i), prog[i]});
      send_word(prog[i], 1'b0);
    end
    s_valid = 1'b0;
    check_done0("t5");
    start0 = 1'b1;
    @(negedge clk1);
    start0 = 1'b0;
    check("t5_run_fall", 32'(run0), 32'd0);
    check("t5_wc_clr",   32'(wc0), 32'd0);
    check("t5_busy",     32'(busy0), 32'd1);

    // 4: reset after byte 2 of word 3, then clean reload
    for (int i = 0; i < 2; i++) begin
      q0.push_back({10'(i), prog[i]});
      send_word(prog[i], 1'b0);
    end
    send_byte(8'hde);
    send_byte(8'had);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t4_wc",    32'(wc0), 32'd0);
    check("t4_busy",  32'(busy0), 32'd0);
    check("t4_run",   32'(run0), 32'd0);
    check("t4_err",   32'(err0), 32'd0);
    check("t4_ready", 32'(bus0.s_ready), 32'd0);
    check("t4_we",    32'(bus0.mem_we), 32'd0);
    check("t4_addr",  32'(bus0.mem_addr), 32'd0);
    check("t4_data",  bus0.mem_wdata, 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    pulse_start(1'b0);
    send_prog(1'b0);
    check_done0("t4");

    // 3: 4-word capacity exhausted without HLT
    sel = 1'b1;
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = {4{8'(8'h11 * (i + 1))}};
      q1.push_back({10'(i), w});
      send_word(w, 1'b0);
    end
    s_valid = 1'b0;
    @(negedge clk1);
    check("t3_err",   32'(err1), 32'd1);
    check("t3_run",   32'(run1), 32'd0);
    check("t3_ready", 32'(bus1.s_ready), 32'd0);
    check("t3_busy",  32'(busy1), 32'd0);
    check("t3_wc",    32'(wc1), 32'd4);
    s_data = 8'h55; s_valid = 1'b1;
    repeat (3) @(negedge clk1);
    s_valid = 1'b0;
    check("t3_wc_sat", 32'(wc1), 32'd4);
    check("t3_writes", 32'(wr1), 32'd4);
    sel = 1'b0;

`ifdef LOADER_CHECKSUM_EN
    // 6: trailing checksum byte; XOR of fc,00,00,00 is fc
    pulse_start(1'b0);
    q0.push_back({10'd0, 32'hfc000000});
    send_word(32'hfc000000, 1'b0);
    send_byte(8'hfc);
    s_valid = 1'b0;
    @(negedge clk1);
    check("t6_ok_run", 32'(run0), 32'd1);
    check("t6_ok_err", 32'(err0), 32'd0);
    pulse_start(1'b0);
    q0.push_back({10'd0, 32'hfc000000});
    send_word(32'hfc000000, 1'b0);
    send_byte(8'h00);
    s_valid = 1'b0;
    @(negedge clk1);
    check("t6_bad_err", 32'(err0), 32'd1);
    check("t6_bad_run", 32'(run0), 32'd0);
    check("t6_left",    32'(q0.size()), 32'd0);
`endif

    repeat (2) @(negedge clk1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
